axi_cache_wb: RTL and testbench
===============================

AXI_CACHE_WB -- requirements
Module: axi_cache_wb

Interface
REQ-001 SHALL provide parameter BEATS, 16, number of 32-bit beats per cache line.
REQ-002 SHALL provide parameter WB_ID, 4'b0001, AXI write ID driven on awid and wid.
REQ-003 SHALL have port aclk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port aresetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port wb_req  input  1  cache requests write-back of one dirty line.
REQ-006 SHALL have port wb_addr  input  32  line address; bits [5:0] ignored.
REQ-007 SHALL have port wb_data  input  512  line data; beat i = wb_data[32*i+31:32*i].
REQ-008 SHALL have port wb_ready  output  1  block idle and able to accept wb_req.
REQ-009 SHALL have port wb_done  output  1  one-cycle pulse when the write response is received.
REQ-010 SHALL have port wb_err  output  1  one-cycle pulse, coincident with wb_done, when bresp != 2'b00.
REQ-011 SHALL have AW ports: awid out 4, awaddr out 32, awlen out 8, awsize out 3, awburst out 2, awlock out 2, awcache out 4, awprot out 3, awvalid out 1, awready in 1.
REQ-012 SHALL have W ports: wid out 4, wdata out 32, wstrb out 4, wlast out 1, wvalid out 1, wready in 1.
REQ-013 SHALL have B ports: bid in 4, bresp in 2, bvalid in 1, bready out 1.

Function
REQ-014 SHALL implement FSM with states IDLE, AW, W, B.
REQ-015 SHALL assert wb_ready only in IDLE; a request is accepted when wb_req && wb_ready.
REQ-016 SHALL, on acceptance, capture {wb_addr[31:6],6'b0} and all 512 data bits in the same cycle, move to AW, and ignore wb_addr/wb_data afterwards.
REQ-017 SHALL, in AW, drive awvalid=1 and awaddr=captured address, holding both stable until awready; awready in the same cycle awvalid rises completes the handshake.
REQ-018 SHALL drive these constants at all times: awlen=BEATS-1 (8'h0f), awsize=3'b010, awburst=2'b01, awlock=2'b00, awcache=4'b0000, awprot=3'b000, wstrb=4'hf, awid=wid=WB_ID.
REQ-019 SHALL, on the AW handshake, move to W with beat counter = 0; wvalid SHALL NOT be asserted before the AW handshake.
REQ-020 SHALL, in W, drive wvalid=1 and wdata=captured beat[counter], holding both stable until wready.
REQ-021 SHALL increment the 4-bit counter on each wvalid && wready.
REQ-022 SHALL assert wlast only when counter == BEATS-1.
REQ-023 SHALL, on wlast && wready, move to B; wvalid SHALL deassert the next cycle.
REQ-024 SHALL accept wready low for any number of cycles without dropping or repeating beats.
REQ-025 SHALL, in B, drive bready=1; on bvalid it SHALL pulse wb_done (and wb_err if bresp != 0) for one cycle and return to IDLE.
REQ-026 SHALL ignore bid.
REQ-027 SHALL assert wb_ready again in the cycle after wb_done.
REQ-028 SHALL ignore bvalid outside state B.
REQ-029 SHALL ignore wb_req asserted while not in IDLE; the cache must hold it.
REQ-030 SHALL have a latency from acceptance to awvalid of 1 cycle; a zero-wait transfer SHALL take 1 AW + 16 W + 1 B cycles.

Reset
REQ-031 SHALL, with aresetn low at a clock edge, enter IDLE, clear the counter, and drive awvalid=wvalid=wlast=bready=wb_done=wb_err=0 and wb_ready=1 from the following cycle.
REQ-032 SHALL abandon any burst in progress on reset mid-operation, without completing the remaining beats.
REQ-033 SHALL NOT need a data buffer reset; buffer contents are don't-care in IDLE.

Structure
REQ-034 SHALL take the AXI constants (burst length, size, INCR burst code, OKAY resp) and the FSM state encoding from the shared CPU package, which the read-side merge logic also uses.
REQ-035 SHALL use no sub-module; the line buffer and beat mux are inline.

Verification
REQ-036 SHALL cover: wb_addr=32'h1FC0_0047, data words 0..15 = 32'hA000_0000+i, all readies high -> awaddr=32'h1FC0_0040 and awlen=8'h0f; beats A0000000..A000000F with wlast on beat 15; wb_done 18 cycles after acceptance.
REQ-037 SHALL cover: awready held low 5 cycles -> awvalid/awaddr stable, wvalid=0 throughout, then normal burst.
REQ-038 SHALL cover: wready random 50% -> exactly 16 handshakes, in order, no duplicates, wlast only on the 16th.
REQ-039 SHALL cover: bresp=2'b10 -> wb_done=1 and wb_err=1 in the same single cycle; wb_ready=1 the next cycle.
REQ-040 SHALL cover: aresetn low during beat 7 -> outputs as in REQ-031 the next cycle; a new request after reset restarts at beat 0.
REQ-041 SHALL cover: wb_req held high continuously with new data -> back-to-back bursts, second AW only after first wb_done.

Source files
------------

// File: rtl/axi_cache_wb_pkg.sv
// Shared CPU-side AXI constants and the write-back FSM state encoding.
// Imported by the write-back engine and by the read-side merge logic.
package axi_cache_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } wb_state_e;

    localparam int unsigned LINE_BEATS = 16;
    localparam int unsigned BEAT_BITS  = 32;
    localparam int unsigned LINE_BITS  = LINE_BEATS * BEAT_BITS;

    localparam logic [7:0] AXI_LEN_LINE   = 8'(LINE_BEATS - 1);
    localparam logic [2:0] AXI_SIZE_32    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_cache_wb.sv
// Cache line write-back engine: captures one dirty line and emits it as a
// single INCR burst of 32-bit beats on an AXI3 write channel.
module axi_cache_wb
    import axi_cache_wb_pkg::*;
#(
    parameter int unsigned BEATS = LINE_BEATS,
    parameter logic [3:0]  WB_ID = 4'b0001
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 wb_req,
    input  logic [31:0]          wb_addr,
    input  logic [LINE_BITS-1:0] wb_data,
    output logic                 wb_ready,
    output logic                 wb_done,
    output logic                 wb_err,
    output logic [3:0]           awid,
    output logic [31:0]          awaddr,
    output logic [7:0]           awlen,
    output logic [2:0]           awsize,
    output logic [1:0]           awburst,
    output logic [1:0]           awlock,
    output logic [3:0]           awcache,
    output logic [2:0]           awprot,
    output logic                 awvalid,
    input  logic                 awready,
    output logic [3:0]           wid,
    output logic [31:0]          wdata,
    output logic [3:0]           wstrb,
    output logic                 wlast,
    output logic                 wvalid,
    input  logic                 wready,
    input  logic [3:0]           bid,
    input  logic [1:0]           bresp,
    input  logic                 bvalid,
    output logic                 bready
);

    wb_state_e            state_q, state_d;
    logic [3:0]           beat_q;
    logic [31:0]          addr_q;
    logic [LINE_BITS-1:0] line_q;
    logic                 accept;
    logic                 last_beat;
    logic                 unused_inputs;

    assign accept        = wb_req && wb_ready;
    assign last_beat     = (beat_q == 4'(BEATS - 1));
    assign unused_inputs = ^{wb_addr[5:0], bid};

    assign awid    = WB_ID;
    assign wid     = WB_ID;
    assign awlen   = 8'(BEATS - 1);
    assign awsize  = AXI_SIZE_32;
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign wstrb   = 4'hf;
    assign awaddr  = addr_q;
    assign wdata   = line_q[{beat_q, 5'd0} +: BEAT_BITS];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_AW && awready) begin
                beat_q <= '0;
            end else if (state_q == ST_W && wready) begin
                beat_q <= beat_q + 4'd1;
            end
        end
    end

    // Line buffer needs no reset: it is only read after a fresh capture.
    always_ff @(posedge aclk) begin
        if (accept) begin
            addr_q <= {wb_addr[31:6], 6'b0};
            line_q <= wb_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        wb_ready = 1'b0;
        awvalid  = 1'b0;
        wvalid   = 1'b0;
        wlast    = 1'b0;
        bready   = 1'b0;
        wb_done  = 1'b0;
        wb_err   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wb_ready = 1'b1;
                if (wb_req) state_d = ST_AW;
            end
            ST_AW: begin
                awvalid = 1'b1;
                if (awready) state_d = ST_W;
            end
            ST_W: begin
                wvalid = 1'b1;
                wlast  = last_beat;
                if (wready && last_beat) state_d = ST_B;
            end
            ST_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    wb_done = 1'b1;
                    wb_err  = (bresp != AXI_RESP_OKAY);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_cache_wb.sv
// Directed bench for axi_cache_wb: inputs driven after the falling edge,
// outputs sampled 1ns later, expectations computed per scenario.
module tb_axi_cache_wb;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         wb_req;
    logic [31:0]  wb_addr;
    logic [511:0] wb_data;
    logic         wb_ready, wb_done, wb_err;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst, awlock;
    logic [3:0]   awcache;
    logic [2:0]   awprot;
    logic         awvalid, awready;
    logic [3:0]   wid;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast, wvalid, wready;
    logic [3:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid, bready;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // {wb_ready, awvalid, wvalid, wlast, bready, wb_done, wb_err}
    logic [6:0] ctl;
    assign ctl = {wb_ready, awvalid, wvalid, wlast, bready, wb_done, wb_err};

    localparam logic [6:0] C_IDLE = 7'b1000000;
    localparam logic [6:0] C_AW   = 7'b0100000;
    localparam logic [6:0] C_W    = 7'b0010000;
    localparam logic [6:0] C_WL   = 7'b0011000;
    localparam logic [6:0] C_B    = 7'b0000100;
    localparam logic [6:0] C_DONE = 7'b0000110;
    localparam logic [6:0] C_ERR  = 7'b0000111;

    always #5 aclk = ~aclk;

    axi_cache_wb #(.BEATS(16), .WB_ID(4'b0001)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_ready(wb_ready), .wb_done(wb_done), .wb_err(wb_err),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic cyc();
        @(negedge aclk);
    endtask

    task automatic fill(input logic [31:0] base);
        for (int i = 0; i < 16; i++) wb_data[32*i +: 32] = base + 32'(i);
    endtask

    task automatic test_reset();
        logic [36:0] exp_const;
        aresetn = 1'b0; wb_req = 1'b0; wb_addr = '0; wb_data = '0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
        cyc(); cyc(); #1;
        n_cmp++;
        if (ctl !== C_IDLE) begin
            n_bad++; $display("FAIL reset_ctl got %b want %b", ctl, C_IDLE);
        end
        exp_const = {4'h1, 8'h0f, 3'b010, 2'b01, 2'b00, 4'h0, 3'h0, 4'h1, 4'hf};
        n_cmp++;
        if ({awid, awlen, awsize, awburst, awlock, awcache, awprot, wid, wstrb} !== exp_const) begin
            n_bad++;
            $display("FAIL reset_const got %h want %h",
                     {awid, awlen, awsize, awburst, awlock, awcache, awprot, wid, wstrb}, exp_const);
        end
        cyc(); aresetn = 1'b1; #1;
        n_cmp++;
        if (ctl !== C_IDLE) begin
            n_bad++; $display("FAIL reset_release got %b want %b", ctl, C_IDLE);
        end
    endtask

    // All readies high, bvalid high from the start (ignored until B).
    task automatic test_basic();
        logic [6:0] exp;
        cyc();
        fill(32'hA000_0000); wb_addr = 32'h1FC0_0047;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00; wb_req = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== C_IDLE) begin
            n_bad++; $display("FAIL basic_accept got %b want %b", ctl, C_IDLE);
        end
        for (int k = 1; k <= 19; k++) begin
            cyc();
            if (k == 1) begin
                wb_req = 1'b0; wb_addr = 32'hDEAD_BEEF; fill(32'h5555_0000);
            end
            #1;
            if (k == 1) exp = C_AW;
            else if (k <= 16) exp = C_W;
            else if (k == 17) exp = C_WL;
            else if (k == 18) exp = C_DONE;
            else exp = C_IDLE;
            n_cmp++;
            if (ctl !== exp) begin
                n_bad++; $display("FAIL basic_ctl k=%0d got %b want %b", k, ctl, exp);
            end
            if (k == 1) begin
                n_cmp++;
                if ({awaddr, awlen} !== {32'h1FC0_0040, 8'h0f}) begin
                    n_bad++; $display("FAIL basic_aw got %h/%h want 1fc00040/0f", awaddr, awlen);
                end
            end
            if (k >= 2 && k <= 17) begin
                n_cmp++;
                if (wdata !== 32'hA000_0000 + 32'(k - 2)) begin
                    n_bad++;
                    $display("FAIL basic_wdata beat=%0d got %h want %h", k - 2, wdata, 32'hA000_0000 + 32'(k - 2));
                end
            end
        end
        bvalid = 1'b0;
    endtask

    task automatic test_aw_stall();
        logic [6:0] exp;
        cyc();
        fill(32'hC0DE_0000); wb_addr = 32'h8000_12FF;
        awready = 1'b0; wready = 1'b1; bvalid = 1'b1; wb_req = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            cyc();
            if (k == 1) wb_req = 1'b0;
            if (k == 6) awready = 1'b1;
            #1;
            if (k <= 6) exp = C_AW;
            else if (k <= 21) exp = C_W;
            else if (k == 22) exp = C_WL;
            else if (k == 23) exp = C_DONE;
            else exp = C_IDLE;
            n_cmp++;
            if (ctl !== exp) begin
                n_bad++; $display("FAIL awstall_ctl k=%0d got %b want %b", k, ctl, exp);
            end
            if (k <= 6) begin
                n_cmp++;
                if (awaddr !== 32'h8000_12C0) begin
                    n_bad++; $display("FAIL awstall_addr k=%0d got %h want 800012c0", k, awaddr);
                end
            end
            if (k >= 7 && k <= 22) begin
                n_cmp++;
                if (wdata !== 32'hC0DE_0000 + 32'(k - 7)) begin
                    n_bad++;
                    $display("FAIL awstall_wdata beat=%0d got %h want %h", k - 7, wdata, 32'hC0DE_0000 + 32'(k - 7));
                end
            end
        end
        bvalid = 1'b0;
    endtask

    task automatic test_wready_random();
        int unsigned idx;
        logic [6:0] exp;
        cyc();
        fill(32'h3C00_0000); wb_addr = 32'h0000_1040;
        awready = 1'b1; wready = 1'b0; bvalid = 1'b0; wb_req = 1'b1;
        cyc(); wb_req = 1'b0; #1;
        n_cmp++;
        if (ctl !== C_AW) begin
            n_bad++; $display("FAIL rnd_aw got %b want %b", ctl, C_AW);
        end
        idx = 0;
        for (int g = 0; g < 300 && idx < 16; g++) begin
            cyc();
            wready = 1'($urandom_range(0, 1));
            #1;
            exp = (idx == 15) ? C_WL : C_W;
            n_cmp++;
            if (ctl !== exp) begin
                n_bad++; $display("FAIL rnd_ctl idx=%0d got %b want %b", idx, ctl, exp);
            end
            n_cmp++;
            if (wdata !== 32'h3C00_0000 + idx) begin
                n_bad++; $display("FAIL rnd_wdata idx=%0d got %h want %h", idx, wdata, 32'h3C00_0000 + idx);
            end
            if (wready) idx++;
        end
        n_cmp++;
        if (idx != 16) begin
            n_bad++; $display("FAIL rnd_timeout got %0d beats want 16", idx);
        end
        cyc(); wready = 1'b1; #1;
        n_cmp++;
        if (ctl !== C_B) begin
            n_bad++; $display("FAIL rnd_after_last got %b want %b", ctl, C_B);
        end
        cyc(); bvalid = 1'b1; #1;
        n_cmp++;
        if (ctl !== C_DONE) begin
            n_bad++; $display("FAIL rnd_done got %b want %b", ctl, C_DONE);
        end
        cyc(); bvalid = 1'b0; #1;
        n_cmp++;
        if (ctl !== C_IDLE) begin
            n_bad++; $display("FAIL rnd_idle got %b want %b", ctl, C_IDLE);
        end
    endtask

    task automatic test_bresp_err();
        logic [6:0] exp;
        cyc();
        fill(32'h0BAD_0000); wb_addr = 32'h4000_0000;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0; wb_req = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            cyc();
            if (k == 1) wb_req = 1'b0;
            if (k == 21) begin bvalid = 1'b1; bresp = 2'b10; bid = 4'h7; end
            if (k == 22) begin bvalid = 1'b0; bresp = 2'b00; bid = 4'h0; end
            #1;
            if (k == 1) exp = C_AW;
            else if (k <= 16) exp = C_W;
            else if (k == 17) exp = C_WL;
            else if (k <= 20) exp = C_B;
            else if (k == 21) exp = C_ERR;
            else exp = C_IDLE;
            n_cmp++;
            if (ctl !== exp) begin
                n_bad++; $display("FAIL err_ctl k=%0d got %b want %b", k, ctl, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] exp;
        cyc();
        fill(32'h7700_0000); wb_addr = 32'h0000_2000;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; wb_req = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (k == 1) wb_req = 1'b0;
            if (k == 9) aresetn = 1'b0;
            if (k == 10) aresetn = 1'b1;
            #1;
            exp = (k == 1) ? C_AW : (k == 10) ? C_IDLE : C_W;
            n_cmp++;
            if (ctl !== exp) begin
                n_bad++; $display("FAIL rstmid_ctl k=%0d got %b want %b", k, ctl, exp);
            end
            if (k == 9) begin
                n_cmp++;
                if (wdata !== 32'h7700_0007) begin
                    n_bad++; $display("FAIL rstmid_beat7 got %h want 77000007", wdata);
                end
            end
        end
        cyc();
        fill(32'h9900_0000); wb_addr = 32'h0000_3000; wb_req = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            cyc();
            if (k == 1) wb_req = 1'b0;
            #1;
            if (k == 1) exp = C_AW;
            else if (k <= 16) exp = C_W;
            else if (k == 17) exp = C_WL;
            else if (k == 18) exp = C_DONE;
            else exp = C_IDLE;
            n_cmp++;
            if (ctl !== exp) begin
                n_bad++; $display("FAIL rstmid_new_ctl k=%0d got %b want %b", k, ctl, exp);
            end
            if (k >= 2 && k <= 17) begin
                n_cmp++;
                if (wdata !== 32'h9900_0000 + 32'(k - 2)) begin
                    n_bad++;
                    $display("FAIL rstmid_new_wdata beat=%0d got %h want %h", k - 2, wdata, 32'h9900_0000 + 32'(k - 2));
                end
            end
        end
        bvalid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [6:0]  exp;
        logic [31:0] base, addr;
        int          j;
        cyc();
        fill(32'h1100_0000); wb_addr = 32'h0000_4000;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; wb_req = 1'b1;
        for (int k = 1; k <= 38; k++) begin
            cyc();
            if (k == 1) begin fill(32'h2200_0000); wb_addr = 32'h0000_5000; end
            if (k == 37) wb_req = 1'b0;
            #1;
            j    = (k <= 18) ? k : k - 19;
            base = (k <= 18) ? 32'h1100_0000 : 32'h2200_0000;
            addr = (k <= 18) ? 32'h0000_4000 : 32'h0000_5000;
            if (k == 38 || j == 0) exp = C_IDLE;
            else if (j == 1) exp = C_AW;
            else if (j <= 16) exp = C_W;
            else if (j == 17) exp = C_WL;
            else exp = C_DONE;
            n_cmp++;
            if (ctl !== exp) begin
                n_bad++; $display("FAIL b2b_ctl k=%0d got %b want %b", k, ctl, exp);
            end
            if (j == 1) begin
                n_cmp++;
                if (awaddr !== addr) begin
                    n_bad++; $display("FAIL b2b_awaddr k=%0d got %h want %h", k, awaddr, addr);
                end
            end
            if (k != 38 && j >= 2 && j <= 17) begin
                n_cmp++;
                if (wdata !== base + 32'(j - 2)) begin
                    n_bad++; $display("FAIL b2b_wdata k=%0d got %h want %h", k, wdata, base + 32'(j - 2));
                end
            end
        end
        bvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_aw_stall();
        test_wready_random();
        test_bresp_err();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
